// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ILLEGAL = 4'd10
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_EXT  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/mc_condlogic.sv
// Flags register, latched condition result and the ARM condition-code check.
module mc_condlogic
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic       i_cond_load,
  input  logic [1:0] i_flag_w,
  output logic       o_cond_q,
  output logic [3:0] o_flags
);

  logic [3:0] r_flags;
  logic       r_cond_q;
  logic       w_cond_ok;

  function automatic logic condcheck(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v, ge;
    {n, z, c, v} = flags;
    ge = (n == v);
    case (cond)
      COND_EQ: condcheck = z;
      COND_NE: condcheck = ~z;
      COND_CS: condcheck = c;
      COND_CC: condcheck = ~c;
      COND_MI: condcheck = n;
      COND_PL: condcheck = ~n;
      COND_VS: condcheck = v;
      COND_VC: condcheck = ~v;
      COND_HI: condcheck = c & ~z;
      COND_LS: condcheck = ~(c & ~z);
      COND_GE: condcheck = ge;
      COND_LT: condcheck = ~ge;
      COND_GT: condcheck = ~z & ge;
      COND_LE: condcheck = ~(~z & ge);
      COND_AL: condcheck = 1'b1;
      default: condcheck = 1'b0;
    endcase
  endfunction

  assign w_cond_ok = condcheck(i_cond, r_flags);

  // Flag writes are gated by the condition latched during DECODE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags  <= 4'b0000;
      r_cond_q <= 1'b0;
    end else begin
      if (i_cond_load) r_cond_q <= w_cond_ok;
      if (i_flag_w[1] && r_cond_q) r_flags[3:2] <= i_alu_flags[3:2];
      if (i_flag_w[0] && r_cond_q) r_flags[1:0] <= i_alu_flags[1:0];
    end
  end

  assign o_cond_q = r_cond_q;
  assign o_flags  = r_flags;

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: Moore main FSM and ALU decoder around mc_condlogic.
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 4,
  parameter bit          EN_EOR    = 1'b1,
  parameter bit          EN_TST    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           Cond,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           RegSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 IllegalInstr,
  output logic [3:0]           State
);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] w_cmd;
  logic       w_s;
  logic [2:0] w_dec_op;
  logic [2:0] w_alu_op;
  logic       w_no_write;
  logic       w_cmd_legal;
  logic [1:0] w_dec_flag_w;
  logic [1:0] w_flag_w;
  logic       w_cond_load;
  logic       w_cond_q;
  logic [3:0] w_flags;
  logic       w_rd_pc;

  assign w_cmd   = Funct[4:1];
  assign w_s     = Funct[0];
  assign w_rd_pc = (Rd == 4'b1111);

  always_comb begin
    w_dec_op    = ALU_ADD;
    w_no_write  = 1'b0;
    w_cmd_legal = 1'b1;
    case (w_cmd)
      CMD_ADD: w_dec_op = ALU_ADD;
      CMD_SUB: w_dec_op = ALU_SUB;
      CMD_AND: w_dec_op = ALU_AND;
      CMD_ORR: w_dec_op = ALU_ORR;
      CMD_EOR: begin
        w_dec_op    = ALU_EOR;
        w_cmd_legal = EN_EOR;
      end
      CMD_CMP: begin
        w_dec_op   = ALU_SUB;
        w_no_write = 1'b1;
      end
      CMD_TST: begin
        w_dec_op    = ALU_AND;
        w_no_write  = 1'b1;
        w_cmd_legal = EN_TST;
      end
      default: w_cmd_legal = 1'b0;
    endcase
  end

  assign w_dec_flag_w = {w_s, w_s & ((w_cmd == CMD_ADD) | (w_cmd == CMD_SUB) | (w_cmd == CMD_CMP))};

  mc_condlogic u_condlogic (
    .clk         (clk),
    .reset       (reset),
    .i_cond      (Cond),
    .i_alu_flags (ALUFlags),
    .i_cond_load (w_cond_load),
    .i_flag_w    (w_flag_w),
    .o_cond_q    (w_cond_q),
    .o_flags     (w_flags)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   w_state_next = S_MEMADR;
          2'b10:   w_state_next = S_BRANCH;
          2'b00:   w_state_next = !w_cmd_legal ? S_ILLEGAL : (Funct[5] ? S_EXECI : S_EXECR);
          default: w_state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: w_state_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_state_next = S_MEMWB;
      S_EXECR,
      S_EXECI:  w_state_next = S_ALUWB;
      default:  w_state_next = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite      = 1'b0;
    MemWrite     = 1'b0;
    RegWrite     = 1'b0;
    IRWrite      = 1'b0;
    AdrSrc       = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_RD2;
    ResultSrc    = RES_ALUOUT;
    IllegalInstr = 1'b0;
    w_alu_op     = ALU_ADD;
    w_flag_w     = 2'b00;
    w_cond_load  = 1'b0;
    case (r_state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALURESULT;
        w_cond_load = 1'b1;
      end
      S_MEMADR: ALUSrcB = SRCB_EXT;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = w_cond_q;
        PCWrite   = w_cond_q & w_rd_pc;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = w_cond_q;
      end
      S_EXECR,
      S_EXECI: begin
        ALUSrcB  = (r_state == S_EXECI) ? SRCB_EXT : SRCB_RD2;
        w_alu_op = w_dec_op;
        w_flag_w = w_dec_flag_w;
      end
      S_ALUWB: begin
        RegWrite = w_cond_q & ~w_no_write;
        PCWrite  = w_cond_q & ~w_no_write & w_rd_pc;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_EXT;
        ResultSrc = RES_ALURESULT;
        PCWrite   = w_cond_q;
      end
      S_ILLEGAL: IllegalInstr = 1'b1;
      default: ;
    endcase
    // An instruction interrupted by reset must not commit its final write.
    if (reset) begin
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      if (r_state != S_FETCH) PCWrite = 1'b0;
    end
  end

  assign ALUControl = ALUCTRL_W'(w_alu_op);
  assign RegSrc     = {(Op == 2'b01) & ~Funct[0], (Op == 2'b10)};
  assign ImmSrc     = Op;
  assign State      = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller: state sequences, enables, flags and reset.
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;

  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, IllegalInstr;
  logic [1:0] RegSrc, ALUSrcB, ResultSrc, ImmSrc;
  logic [3:0] ALUControl, State;

  logic       PCWrite2, MemWrite2, RegWrite2, IRWrite2, AdrSrc2, ALUSrcA2, IllegalInstr2;
  logic [1:0] RegSrc2, ALUSrcB2, ResultSrc2, ImmSrc2;
  logic [3:0] ALUControl2, State2;

  logic [4:0] en;
  int         n_pass;
  int         n_total;

  mc_controller #(.ALUCTRL_W(4), .EN_EOR(1'b1), .EN_TST(1'b1)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .IllegalInstr(IllegalInstr), .State(State)
  );

  mc_controller #(.ALUCTRL_W(4), .EN_EOR(1'b0), .EN_TST(1'b1)) dut_noeor (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite2), .MemWrite(MemWrite2), .RegWrite(RegWrite2),
    .IRWrite(IRWrite2), .AdrSrc(AdrSrc2), .RegSrc(RegSrc2), .ALUSrcA(ALUSrcA2),
    .ALUSrcB(ALUSrcB2), .ResultSrc(ResultSrc2), .ImmSrc(ImmSrc2), .ALUControl(ALUControl2),
    .IllegalInstr(IllegalInstr2), .State(State2)
  );

  assign en = {PCWrite, MemWrite, RegWrite, IRWrite, IllegalInstr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input logic [3:0] af);
    Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = af;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_instr(4'b1110, 2'b00, 6'b000000, 4'b0000, 4'b0000);
    tick();
    tick();
    n_total++; if (State !== 4'd0) $display("FAIL reset_state: got %0d expected 0", State); else n_pass++;
    n_total++; if (en !== 5'b10010) $display("FAIL reset_enables: got %b expected 10010", en); else n_pass++;
    n_total++; if (dut.u_condlogic.o_flags !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", dut.u_condlogic.o_flags); else n_pass++;
    n_total++; if (ALUSrcB !== 2'b10) $display("FAIL reset_srcb: got %b expected 10", ALUSrcB); else n_pass++;
    $display("reset: state=%0d enables=%b", State, en);
  endtask

  task automatic test_add_imm(input logic [3:0] rd, input logic [4:0] wb_en);
    logic [3:0] exp_st [4];
    logic [4:0] exp_en [4];
    exp_st = '{4'd0, 4'd1, 4'd7, 4'd8};
    exp_en = '{5'b10010, 5'b00000, 5'b00000, wb_en};
    set_instr(4'b1110, 2'b00, 6'b101000, rd, 4'b0000);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (State !== exp_st[i]) $display("FAIL add_state[%0d]: got %0d expected %0d", i, State, exp_st[i]); else n_pass++;
      n_total++; if (en !== exp_en[i]) $display("FAIL add_enables[%0d]: got %b expected %b", i, en, exp_en[i]); else n_pass++;
      if (i == 2) begin
        n_total++; if (ALUControl !== 4'd0) $display("FAIL add_aluctrl: got %0d expected 0", ALUControl); else n_pass++;
        n_total++; if (ALUSrcB !== 2'b01) $display("FAIL add_srcb: got %b expected 01", ALUSrcB); else n_pass++;
      end
      tick();
    end
    n_total++; if (State !== 4'd0) $display("FAIL add_return: got %0d expected 0", State); else n_pass++;
    $display("add rd=%0d: done, state=%0d", rd, State);
  endtask

  task automatic test_cmp_beq();
    logic [3:0] exp_st [4];
    logic [4:0] exp_en [4];
    exp_st = '{4'd0, 4'd1, 4'd6, 4'd8};
    exp_en = '{5'b10010, 5'b00000, 5'b00000, 5'b00000};
    set_instr(4'b1110, 2'b00, 6'b010101, 4'b0000, 4'b0100);
    for (int i = 0; i < 4; i++) begin
      n_total++; if (State !== exp_st[i]) $display("FAIL cmp_state[%0d]: got %0d expected %0d", i, State, exp_st[i]); else n_pass++;
      n_total++; if (en !== exp_en[i]) $display("FAIL cmp_enables[%0d]: got %b expected %b", i, en, exp_en[i]); else n_pass++;
      if (i == 2) begin
        n_total++; if (ALUControl !== 4'd1) $display("FAIL cmp_aluctrl: got %0d expected 1", ALUControl); else n_pass++;
      end
      tick();
    end
    n_total++; if (dut.u_condlogic.o_flags !== 4'b0100) $display("FAIL cmp_flags: got %b expected 0100", dut.u_condlogic.o_flags); else n_pass++;
    $display("cmp: flags=%b", dut.u_condlogic.o_flags);
    exp_st = '{4'd0, 4'd1, 4'd9, 4'd0};
    exp_en = '{5'b10010, 5'b00000, 5'b10000, 5'b10010};
    set_instr(4'b0000, 2'b10, 6'b100000, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      n_total++; if (State !== exp_st[i]) $display("FAIL beq_state[%0d]: got %0d expected %0d", i, State, exp_st[i]); else n_pass++;
      n_total++; if (en !== exp_en[i]) $display("FAIL beq_enables[%0d]: got %b expected %b", i, en, exp_en[i]); else n_pass++;
      if (i < 3) tick();
    end
    $display("beq: taken, state=%0d", State);
  endtask

  task automatic test_ldr_str();
    logic [3:0] exp_st [5];
    logic [4:0] exp_en [5];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    exp_en = '{5'b10010, 5'b00000, 5'b00000, 5'b00000, 5'b00100};
    set_instr(4'b1110, 2'b01, 6'b011001, 4'b0011, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      n_total++; if (State !== exp_st[i]) $display("FAIL ldr_state[%0d]: got %0d expected %0d", i, State, exp_st[i]); else n_pass++;
      n_total++; if (en !== exp_en[i]) $display("FAIL ldr_enables[%0d]: got %b expected %b", i, en, exp_en[i]); else n_pass++;
      if (i == 3) begin
        n_total++; if (AdrSrc !== 1'b1) $display("FAIL ldr_adrsrc: got %b expected 1", AdrSrc); else n_pass++;
      end
      tick();
    end
    $display("ldr: done, state=%0d", State);
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    exp_en = '{5'b10010, 5'b00000, 5'b00000, 5'b01000, 5'b10010};
    set_instr(4'b1110, 2'b01, 6'b011000, 4'b0011, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      n_total++; if (State !== exp_st[i]) $display("FAIL str_state[%0d]: got %0d expected %0d", i, State, exp_st[i]); else n_pass++;
      n_total++; if (en !== exp_en[i]) $display("FAIL str_enables[%0d]: got %b expected %b", i, en, exp_en[i]); else n_pass++;
      if (i < 4) tick();
    end
    $display("str: done, state=%0d", State);
  endtask

  task automatic test_cond_fail();
    logic [3:0] exp_st [4];
    logic [4:0] exp_en [4];
    exp_st = '{4'd0, 4'd1, 4'd7, 4'd8};
    exp_en = '{5'b10010, 5'b00000, 5'b00000, 5'b00000};
    set_instr(4'b0001, 2'b00, 6'b100101, 4'b0010, 4'b1011);
    for (int i = 0; i < 4; i++) begin
      n_total++; if (State !== exp_st[i]) $display("FAIL subne_state[%0d]: got %0d expected %0d", i, State, exp_st[i]); else n_pass++;
      n_total++; if (en !== exp_en[i]) $display("FAIL subne_enables[%0d]: got %b expected %b", i, en, exp_en[i]); else n_pass++;
      tick();
    end
    n_total++; if (dut.u_condlogic.o_flags !== 4'b0100) $display("FAIL subne_flags: got %b expected 0100", dut.u_condlogic.o_flags); else n_pass++;
    $display("subne: skipped, flags=%b", dut.u_condlogic.o_flags);
  endtask

  task automatic test_illegal(input logic [1:0] op, input logic [5:0] funct);
    logic [3:0] exp_st [4];
    logic [4:0] exp_en [4];
    exp_st = '{4'd0, 4'd1, 4'd10, 4'd0};
    exp_en = '{5'b10010, 5'b00000, 5'b00001, 5'b10010};
    set_instr(4'b1110, op, funct, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      n_total++; if (State !== exp_st[i]) $display("FAIL illegal_state[%0d]: got %0d expected %0d", i, State, exp_st[i]); else n_pass++;
      n_total++; if (en !== exp_en[i]) $display("FAIL illegal_enables[%0d]: got %b expected %b", i, en, exp_en[i]); else n_pass++;
      if (i < 3) tick();
    end
    $display("illegal op=%b funct=%b: state=%0d", op, funct, State);
  endtask

  task automatic test_eor();
    logic [3:0] exp_st [4];
    logic [3:0] exp_st2 [3];
    exp_st  = '{4'd0, 4'd1, 4'd6, 4'd8};
    exp_st2 = '{4'd0, 4'd1, 4'd10};
    set_instr(4'b1110, 2'b00, 6'b000010, 4'b0001, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      n_total++; if (State !== exp_st[i]) $display("FAIL eor_state[%0d]: got %0d expected %0d", i, State, exp_st[i]); else n_pass++;
      if (i < 3) begin
        n_total++; if (State2 !== exp_st2[i]) $display("FAIL noeor_state[%0d]: got %0d expected %0d", i, State2, exp_st2[i]); else n_pass++;
      end
      if (i == 2) begin
        n_total++; if (ALUControl !== 4'd4) $display("FAIL eor_aluctrl: got %0d expected 4", ALUControl); else n_pass++;
        n_total++; if (IllegalInstr2 !== 1'b1) $display("FAIL noeor_illegal: got %b expected 1", IllegalInstr2); else n_pass++;
        n_total++; if (IllegalInstr !== 1'b0) $display("FAIL eor_illegal: got %b expected 0", IllegalInstr); else n_pass++;
      end
      if (i == 3) begin
        n_total++; if (RegWrite !== 1'b1) $display("FAIL eor_regwrite: got %b expected 1", RegWrite); else n_pass++;
      end
      tick();
    end
    $display("eor: state=%0d", State);
  endtask

  task automatic test_reset_mid();
    set_instr(4'b1110, 2'b01, 6'b011000, 4'b0011, 4'b0000);
    for (int i = 0; i < 3; i++) tick();
    n_total++; if (State !== 4'd5) $display("FAIL rstmid_pre_state: got %0d expected 5", State); else n_pass++;
    n_total++; if (MemWrite !== 1'b1) $display("FAIL rstmid_pre_memwrite: got %b expected 1", MemWrite); else n_pass++;
    reset = 1'b1;
    tick();
    n_total++; if (State !== 4'd0) $display("FAIL rstmid_state: got %0d expected 0", State); else n_pass++;
    n_total++; if (MemWrite !== 1'b0) $display("FAIL rstmid_memwrite: got %b expected 0", MemWrite); else n_pass++;
    n_total++; if (dut.u_condlogic.o_flags !== 4'b0000) $display("FAIL rstmid_flags: got %b expected 0000", dut.u_condlogic.o_flags); else n_pass++;
    reset = 1'b0;
    tick();
    n_total++; if (State !== 4'd1) $display("FAIL rstmid_restart: got %0d expected 1", State); else n_pass++;
    $display("reset mid-instruction: state=%0d flags=%b", State, dut.u_condlogic.o_flags);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    set_instr(4'b0000, 2'b00, 6'b000000, 4'b0000, 4'b0000);
    test_reset();
    test_add_imm(4'b0000, 5'b00100);
    test_add_imm(4'b1111, 5'b10100);
    test_cmp_beq();
    test_ldr_str();
    test_cond_fail();
    test_illegal(2'b11, 6'b000000);
    test_illegal(2'b00, 6'b011110);
    test_eor();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multicycle ARM control unit that succeeds the single-cycle decoder. It takes the same instruction fields (Cond, Op, Funct, Rd) plus the ALU flags, and sequences each instruction through a Moore main FSM. It also contains the ALU decoder, the flags register and the condition-check logic. It sits between the instruction register and a shared-memory multicycle datapath.

Parameters:
ALUCTRL_W, 4, width of ALUControl; must be >= 3; op codes are zero-extended.
EN_EOR, 1, decode EOR (cmd 0001); when 0, EOR is illegal.
EN_TST, 1, decode TST (cmd 1000, NoWrite); when 0, TST is illegal.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
Cond  in  4  Instr[31:28]
Op  in  2  Instr[27:26]
Funct  in  6  Instr[25:20]
Rd  in  4  Instr[15:12]
ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle
PCWrite  out  1  PC register enable
MemWrite  out  1  memory write enable
RegWrite  out  1  register file write enable
IRWrite  out  1  instruction register enable
AdrSrc  out  1  0 = PC, 1 = ALUResult register
RegSrc  out  2  register-address muxes, same meaning as in the single-cycle decoder
ALUSrcA  out  1  0 = RD1 register, 1 = PC
ALUSrcB  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ImmSrc  out  2  extender select (Op)
ALUControl  out  ALUCTRL_W  ALU operation
IllegalInstr  out  1  one-cycle pulse on an undecodable instruction
State  out  4  FSM state, for debug

Behaviour:
- States, in encoding order: FETCH=0, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, ILLEGAL.
- On reset: State=FETCH and Flags=0000 on the next edge. cond_q is cleared. All enables are low except FETCH's own decode outputs.
- Transitions:
  - FETCH -> DECODE.
  - DECODE:
    - Op=01 -> MEMADR.
    - Op=00 with Funct[5]=0 -> EXECR; with Funct[5]=1 -> EXECI.
    - Op=10 -> BRANCH.
    - Op=11, or an unsupported cmd -> ILLEGAL.
  - MEMADR -> MEMRD if Funct[0]=1 (LDR), else MEMWR.
  - MEMRD -> MEMWB.
  - MEMWB, MEMWR, BRANCH, ILLEGAL -> FETCH.
  - EXECR and EXECI -> ALUWB -> FETCH.
- Latency:
  - Data processing: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
  - Illegal: 3 cycles.
- FETCH outputs: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALU op ADD, PC+4 write (unconditional).
- DECODE outputs: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ADD. Computes PC+8.
- Conditional execution:
  - In DECODE, cond_q is loaded with condcheck(Cond, Flags).
  - Codes: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; 1111 gives 0.
  - cond_q gates these outputs: MemWrite (MEMWR), RegWrite (MEMWB, ALUWB), BRANCH's PCWrite and the flag writes.
- PCS = ((Rd=1111) & RegW) | Branch. When PCS=1 in MEMWB or ALUWB, PCWrite = cond_q.
- ALU decoding uses cmd=Funct[4:1] and S=Funct[0], and applies in EXECR/EXECI only:
  - ADD 0100 -> 0
  - SUB 0010 -> 1
  - AND 0000 -> 2
  - ORR 1100 -> 3
  - EOR 0001 -> 4
  - CMP 1010 -> 1, NoWrite
  - TST 1000 -> 2, NoWrite
  - Every other state uses ADD.
- Flags:
  - FlagW[1] = S; it writes N and Z.
  - FlagW[0] = S & (ADD|SUB|CMP); it writes C and V.
  - Flags are captured from ALUFlags at the end of EXECR/EXECI when cond_q=1.
- NoWrite: ALUWB still visited; RegWrite=0; PCWrite=0.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD.
- MEMRD and MEMWR: AdrSrc=1.
- MEMWB: ResultSrc=01.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ADD.
- ILLEGAL: IllegalInstr=1; no writes of any kind.
- Reset mid-instruction: abandoned; next state FETCH; no pending write completes.

Decomposition:
- Package mc_pkg holds:
  - state_t enum;
  - ALU op constants ALU_ADD..ALU_EOR;
  - cond code constants;
  - the ALUSrcB and ResultSrc encodings.
- Sub-module mc_condlogic holds the Flags register, cond_q and condcheck.
- The FSM and ALU decoder stay in the top module.

Test Plan:
- Reset held 2 cycles, then released with ADD R0,R1,#42 (Op=00, Funct=101000, Rd=0000, Cond=1110) -> State sequence 0,1,7,8,0; ALUControl=0 in EXECI; RegWrite=1 only in ALUWB; PCWrite=1 only in FETCH.
- CMP R1,R2 (Funct=010101) with ALUFlags=0100 in EXECR -> ALUWB has RegWrite=0; Flags=0100 afterwards; a following BEQ (Cond=0000, Op=10) gives PCWrite=1 in BRANCH.
- LDR (Op=01, Funct=011001) -> 5 cycles (0,1,2,3,4); AdrSrc=1 in MEMRD; RegWrite=1 in MEMWB. STR (Funct=011000) -> MemWrite=1 only in MEMWR.
- SUBNE with Z=1 (Cond=0001) -> full ALUWB path; RegWrite=0; Flags unchanged; PCWrite low except FETCH.
- Op=11, then cmd=1111 -> IllegalInstr=1 for exactly one cycle each, then FETCH. With EN_EOR=0, EOR also gives IllegalInstr.
- Reset asserted while State=MEMWR -> MemWrite=0 in that cycle's successor; State=FETCH; Flags=0000.
